alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared combinational `ALU` (8-bit operands, 2-bit op select, 17-bit result). It accepts operation requests over valid/ready handshakes and latches the winning request's operands into the ALU. It registers the result and returns it, tagged with the requester ID, over a response handshake. It sits between client blocks and the single ALU instance, so the ALU is never driven by two sources.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `i_clk` input 1: clock; all logic on rising edge.
- `i_rst_n` input 1: reset, synchronous and active-low.
- `i_req0_valid` / `i_req1_valid` input 1: request pending from requester 0/1.
- `o_req0_ready` / `o_req1_ready` output 1: request accepted this cycle.
- `i_req0_a` / `i_req1_a` input 8: operand A.
- `i_req0_b` / `i_req1_b` input 8: operand B.
- `i_req0_op` / `i_req1_op` input 2: ALU op select.
- `o_rsp_valid` output 1: result available.
- `i_rsp_ready` input 1: consumer takes the result.
- `o_rsp_id` output 1: requester that owns the result.
- `o_rsp_data` output 17: registered ALU result.
- `o_busy` output 1: high in EXEC or RESP.
- `o_op_count` output CNT_W: number of completed responses; wraps modulo 2^CNT_W.

## Operation
- FSM states:
  - IDLE: arbitrate among valid requesters.
  - EXEC: latched operands drive the ALU.
  - RESP: hold the result until it is taken.
- Transitions:
  - IDLE → EXEC on any accepted request.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when `o_rsp_valid && i_rsp_ready`.
- Arbitration:
  - Applies in IDLE only.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester that was not granted last wins.
  - Pointer `last_id` updates on each accept.
- Ready signals:
  - `o_reqN_ready = (state==IDLE) && grant==N`, decoded combinationally.
  - Ready may depend on valid. Requesters must not make valid depend on ready.
  - Once asserted, a requester holds valid and payload stable until accepted.
- Accept cycle: latch a, b, op and the winning ID into internal registers.
- Result capture: in EXEC, the ALU output from the latched operands is captured into `o_rsp_data`. `o_rsp_id` is set from the latched ID.
- The ALU inputs are driven only from the latched registers, never directly from request ports.
- The result is full 17-bit ALU output with no truncation or sign handling in this block.
- `o_op_count` increments by 1 on each response handshake, wrapping from all-ones to 0.

## Timing
- Reset (`i_rst_n`=0 at a clock edge):
  - state=IDLE, `last_id`=1, so requester 0 wins the first tie.
  - Latched operands and op = 0.
  - `o_rsp_valid`=0, `o_rsp_id`=0, `o_rsp_data`=0, `o_busy`=0, `o_op_count`=0.
  - `o_reqN_ready`=0 while reset is asserted.
- Latency:
  - Accept at cycle T.
  - `o_rsp_valid`=1 from cycle T+2.
  - With `i_rsp_ready` already high, the handshake occurs at T+2, the block is in IDLE at T+3, and the next accept can happen at T+3.
  - Peak throughput is 1 operation per 3 cycles.
- Backpressure: in RESP with `i_rsp_ready`=0, `o_rsp_valid`, `o_rsp_id` and `o_rsp_data` hold stable indefinitely.
- Requests arriving outside IDLE see ready=0 and stay pending, with no loss.
- Both requesters valid continuously: grants alternate 0,1,0,1…
- Reset during EXEC or RESP:
  - The in-flight result is discarded, with no response and no count increment.
  - The requester is not re-granted automatically for that operation.
- Counter wrap: with `CNT_W`=16, `o_op_count`=16'hFFFF plus one handshake gives 16'h0000.

## Structure
- Package `alu_arb_pkg`:
  - state enum (IDLE, EXEC, RESP);
  - `ALU_OP_W`=2, `ALU_IN_W`=8, `ALU_OUT_W`=17;
  - requester ID width = 1.
- Sub-module `rr_arb2`: two-input round-robin grant logic with `last_id` register, update enable, and `grant`/`grant_valid` outputs.
- One `ALU` instance inside `alu_arbiter`.

## Test plan
- Single request, no backpressure:
  - Stimulus: after reset, req0 a=8'h0F, b=8'h03, op=2'b00, `i_rsp_ready`=1.
  - Required: ready0 pulses at T; `o_rsp_valid` rises at T+2 with id=0 and data equal to the ALU result for those inputs; `o_op_count`=1.
- Tie break:
  - Stimulus: both requesters valid from reset, held valid.
  - Required: grants 0,1,0,1 over four operations; each `o_rsp_id` matches the owner's operands.
- Backpressure:
  - Stimulus: `i_rsp_ready`=0 for 5 cycles in RESP, then 1.
  - Required: data and id stable all 5 cycles; a queued req1 is accepted only after the handshake.
- Reset mid-operation:
  - Stimulus: assert `i_rst_n`=0 during EXEC.
  - Required: next cycle `o_rsp_valid`=0, `o_busy`=0, count unchanged at 0; req0 wins the following tie.
- Counter wrap:
  - Stimulus: `CNT_W`=4, run 17 operations.
  - Required: `o_op_count` goes 15→0→1.
- Sweep:
  - Stimulus: all 4 ops × a,b ∈ {8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF} through both ports.
  - Required: every `o_rsp_data` equals the direct ALU reference output.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-requester ALU arbiter/sequencer.
package alu_arb_pkg;

  localparam int ALU_OP_W  = 2;
  localparam int ALU_IN_W  = 8;
  localparam int ALU_OUT_W = 17;
  localparam int ID_W      = 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_XOR
  } alu_op_t;

  typedef struct packed {
    logic [ALU_IN_W-1:0] a;
    logic [ALU_IN_W-1:0] b;
    logic [ALU_OP_W-1:0] op;
    logic [ID_W-1:0]     id;
  } req_t;

endpackage

// File: rtl/ALU.sv
// Shared combinational ALU: add, subtract (17-bit wrap), multiply, xor.
module ALU
  import alu_arb_pkg::*;
(
  input  logic [ALU_IN_W-1:0]  a,
  input  logic [ALU_IN_W-1:0]  b,
  input  logic [ALU_OP_W-1:0]  op,
  output logic [ALU_OUT_W-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_op_t'(op))
      OP_ADD:  y = ALU_OUT_W'(a) + ALU_OUT_W'(b);
      OP_SUB:  y = ALU_OUT_W'(a) - ALU_OUT_W'(b);
      OP_MUL:  y = ALU_OUT_W'(a) * ALU_OUT_W'(b);
      OP_XOR:  y = ALU_OUT_W'(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic       grant,
  output logic       grant_valid
);

  logic last_id;

  always_comb begin
    grant_valid = |valid;
    if (valid == 2'b11) grant = ~last_id;
    else                grant = valid[1];
  end

  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n)      last_id <= 1'b1;
    else if (update) last_id <= grant;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer that owns the single ALU instance and returns tagged,
// registered results over a valid/ready response handshake.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [ALU_IN_W-1:0]  i_req0_a,
  input  logic [ALU_IN_W-1:0]  i_req0_b,
  input  logic [ALU_OP_W-1:0]  i_req0_op,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [ALU_IN_W-1:0]  i_req1_a,
  input  logic [ALU_IN_W-1:0]  i_req1_b,
  input  logic [ALU_OP_W-1:0]  i_req1_op,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [ALU_OUT_W-1:0] o_rsp_data,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_op_count
);

  state_t               state;
  req_t                 lat;
  req_t                 win_req;
  logic                 grant;
  logic                 grant_valid;
  logic                 accept;
  logic [ALU_OUT_W-1:0] alu_y;

  assign accept       = i_rst_n && (state == IDLE) && grant_valid;
  assign o_req0_ready = accept && !grant;
  assign o_req1_ready = accept && grant;

  rr_arb2 u_arb (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .valid       ({i_req1_valid, i_req0_valid}),
    .update      (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // The ALU only ever sees the latched request, never the request ports.
  ALU u_alu (
    .a  (lat.a),
    .b  (lat.b),
    .op (lat.op),
    .y  (alu_y)
  );

  always_comb begin
    win_req = '0;
    if (grant) win_req = '{a: i_req1_a, b: i_req1_b, op: i_req1_op, id: 1'b1};
    else       win_req = '{a: i_req0_a, b: i_req0_b, op: i_req0_op, id: 1'b0};
  end

  // Reset drops any in-flight operation without responding or counting it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      lat         <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
      o_busy      <= 1'b0;
      o_op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat    <= win_req;
            o_busy <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          o_rsp_data  <= alu_y;
          o_rsp_id    <= lat.id;
          o_rsp_valid <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_op_count  <= o_op_count + CNT_W'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model,
// vector table, directed corner sequences and randomized traffic.
module tb_alu_arbiter;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid0, valid1, ready0, ready1;
  logic [7:0]  a0, b0, a1, b1;
  logic [1:0]  op0, op1;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [16:0] rsp_data;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (valid0),
    .o_req0_ready (ready0),
    .i_req0_a     (a0),
    .i_req0_b     (b0),
    .i_req0_op    (op0),
    .i_req1_valid (valid1),
    .o_req1_ready (ready1),
    .i_req1_a     (a1),
    .i_req1_b     (b1),
    .i_req1_op    (op1),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy),
    .o_op_count   (op_count)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } op_t;

  typedef struct {
    bit          port;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [16:0] exp;
  } vec_t;

  op_t  q0[$], q1[$];
  bit   hs_ids[$];
  vec_t vecs[$];

  int vectors = 0;
  int miscompares = 0;

  bit          pres0 = 0, pres1 = 0, rand_gate = 0;
  bit          m_known = 0, m_pending = 0, m_last = 1, m_id = 0;
  int          m_age = 0, m_count = 0, hs_total = 0;
  logic [16:0] m_data = '0, last_hs_data = '0;
  bit          last_hs_id = 0;

  function automatic logic [16:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [1:0] op);
    int x, y, r;
    x = a;
    y = b;
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x * y;
      default: r = x ^ y;
    endcase
    return r[16:0];
  endfunction

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    if (!pres0 && q0.size() > 0 && (!rand_gate || $urandom_range(0, 1) == 1)) pres0 = 1;
    if (!pres1 && q1.size() > 0 && (!rand_gate || $urandom_range(0, 1) == 1)) pres1 = 1;
    valid0 = pres0;
    valid1 = pres1;
    if (pres0) begin a0 = q0[0].a; b0 = q0[0].b; op0 = q0[0].op; end
    else begin a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom); end
    if (pres1) begin a1 = q1[0].a; b1 = q1[0].b; op1 = q1[0].op; end
    else begin a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom); end
  endtask

  // One clock: drive, compare against the model mid-cycle, advance the model.
  task automatic cycle();
    bit w, er0, er1, ev;
    op_t o;
    applyStimulus();
    #3;
    er0 = 0;
    er1 = 0;
    w   = 0;
    if (rst_n && !m_pending && (valid0 || valid1)) begin
      w   = (valid0 && valid1) ? !m_last : valid1;
      er0 = !w;
      er1 = w;
    end
    ev = m_pending && (m_age >= 2);
    if (m_known) begin
      checkOutput("ready0", ready0, er0);
      checkOutput("ready1", ready1, er1);
      checkOutput("rsp_valid", rsp_valid, ev);
      checkOutput("busy", busy, m_pending);
      checkOutput("op_count", op_count, m_count);
      if (ev) begin
        checkOutput("rsp_id", rsp_id, m_id);
        checkOutput("rsp_data", rsp_data, m_data);
      end
    end
    if (!rst_n) begin
      m_known   = 1;
      m_pending = 0;
      m_last    = 1;
      m_count   = 0;
    end else if (er0 || er1) begin
      if (w) begin o = q1.pop_front(); pres1 = 0; end
      else   begin o = q0.pop_front(); pres0 = 0; end
      m_data    = alu_ref(o.a, o.b, o.op);
      m_id      = w;
      m_last    = w;
      m_pending = 1;
      m_age     = 1;
    end else if (m_pending) begin
      if (ev && rsp_ready) begin
        m_count      = (m_count + 1) % (1 << CNT_W);
        last_hs_id   = m_id;
        last_hs_data = m_data;
        hs_ids.push_back(m_id);
        hs_total++;
        m_pending = 0;
      end else begin
        m_age++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runUntil(int n_hs, int budget);
    int start = hs_total;
    int c = 0;
    while (hs_total < start + n_hs && c < budget) begin
      cycle();
      c++;
    end
    checkOutput("handshake_budget", 32'(hs_total - start >= n_hs), 1);
  endtask

  task automatic doReset();
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
  endtask

  function automatic op_t mk(logic [7:0] a, logic [7:0] b, logic [1:0] op);
    op_t o;
    o.a = a;
    o.b = b;
    o.op = op;
    return o;
  endfunction

  initial begin
    logic [7:0] corner [5];
    int budget;
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'hFF;

    vecs.push_back('{0, 8'h0F, 8'h03, 2'd0, 17'h00012});
    vecs.push_back('{1, 8'hFF, 8'hFF, 2'd2, 17'h0FE01});
    vecs.push_back('{0, 8'h00, 8'h01, 2'd1, 17'h1FFFF});
    vecs.push_back('{1, 8'hAA, 8'h55, 2'd3, 17'h000FF});
    vecs.push_back('{0, 8'hFF, 8'hFF, 2'd0, 17'h001FE});
    for (int p = 0; p < 2; p++)
      for (int op = 0; op < 4; op++)
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            vecs.push_back('{p[0], corner[i], corner[j], op[1:0],
                             alu_ref(corner[i], corner[j], op[1:0])});

    rsp_ready = 1;
    valid0 = 0;
    valid1 = 0;
    @(posedge clk);
    #1;
    doReset();
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_count", op_count, 0);

    // Vector table: single requests through either port.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].port) q1.push_back(mk(vecs[i].a, vecs[i].b, vecs[i].op));
      else              q0.push_back(mk(vecs[i].a, vecs[i].b, vecs[i].op));
      runUntil(1, 20);
      checkOutput("vec_data", last_hs_data, vecs[i].exp);
      checkOutput("vec_id", last_hs_id, vecs[i].port);
      if (i == 0) checkOutput("single_count", op_count, 1);
    end

    // Tie break from reset: both held valid, grants must alternate.
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      q0.push_back(mk(8'h10 + 8'(k), 8'h01, 2'd0));
      q1.push_back(mk(8'h20 + 8'(k), 8'h02, 2'd2));
    end
    cycle();
    rst_n = 1;
    hs_ids.delete();
    runUntil(4, 40);
    for (int k = 0; k < 4; k++)
      checkOutput("tie_order", (k < hs_ids.size()) ? 32'(hs_ids[k]) : 32'hDEAD, 32'(k % 2));

    // Backpressure: result held for 5 cycles, queued req1 waits for handshake.
    rsp_ready = 0;
    hs_ids.delete();
    q0.push_back(mk(8'h33, 8'h44, 2'd2));
    budget = 0;
    while (!(m_pending && m_age >= 2) && budget < 10) begin
      cycle();
      budget++;
    end
    q1.push_back(mk(8'h05, 8'h09, 2'd1));
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid", rsp_valid, 1);
      checkOutput("bp_data", rsp_data, alu_ref(8'h33, 8'h44, 2'd2));
      checkOutput("bp_id", rsp_id, 0);
      cycle();
    end
    rsp_ready = 1;
    runUntil(2, 20);
    checkOutput("bp_order0", (hs_ids.size() > 0) ? 32'(hs_ids[0]) : 32'hDEAD, 0);
    checkOutput("bp_order1", (hs_ids.size() > 1) ? 32'(hs_ids[1]) : 32'hDEAD, 1);

    // Reset during EXEC drops the operation; req0 wins the next tie.
    doReset();
    q0.push_back(mk(8'h12, 8'h34, 2'd0));
    budget = 0;
    while (!(m_pending && m_age == 1) && budget < 10) begin
      cycle();
      budget++;
    end
    checkOutput("exec_busy", busy, 1);
    rst_n = 0;
    cycle();
    rst_n = 1;
    checkOutput("rst_mid_valid", rsp_valid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_count", op_count, 0);
    hs_ids.delete();
    q0.push_back(mk(8'h01, 8'h02, 2'd0));
    q1.push_back(mk(8'h03, 8'h04, 2'd0));
    runUntil(2, 20);
    checkOutput("rst_tie_id", (hs_ids.size() > 0) ? 32'(hs_ids[0]) : 32'hDEAD, 0);

    // Counter wrap with a 4-bit counter: 15 -> 0 -> 1.
    doReset();
    for (int k = 1; k <= 17; k++) begin
      q0.push_back(mk(8'($urandom), 8'($urandom), 2'($urandom)));
      runUntil(1, 20);
      checkOutput("wrap_count", op_count, k % 16);
    end

    // Randomized traffic with random backpressure and presentation delay.
    rand_gate = 1;
    for (int c = 0; c < 1500; c++) begin
      if (q0.size() < 4 && $urandom_range(0, 3) == 0)
        q0.push_back(mk(8'($urandom), 8'($urandom), 2'($urandom)));
      if (q1.size() < 4 && $urandom_range(0, 3) == 0)
        q1.push_back(mk(8'($urandom), 8'($urandom), 2'($urandom)));
      rsp_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    rand_gate = 0;
    rsp_ready = 1;
    budget = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_pending) && budget < 200) begin
      cycle();
      budget++;
    end
    checkOutput("random_drain", 32'(q0.size() + q1.size() + 32'(m_pending)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
